// File: rtl/debounce_defs.sv
// Shared definitions for the debounce stage: FSM state encoding and default
// stability window.
package debounce_defs;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  // 10 ms at 100 MHz
  localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reusable for any
// board-level signal entering the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync1_reg;
  logic sync2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= d;
      sync2_reg <= sync1_reg;
    end
  end

  assign q = sync2_reg;

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw switch/button input into a clean level with one-cycle
// rising and falling edge ticks.
module debounce_edge
  import debounce_defs::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             sync2;
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             rise_reg;
  logic             rise_next;
  logic             fall_reg;
  logic             fall_next;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_in),
    .q     (sync2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ZERO;
      cnt_reg   <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  // Ticks are decided on the same edge that completes the WAIT window, so
  // they register together with the state change into ONE/ZERO.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      ZERO: begin
        if (sync2) begin
          state_next = WAIT1;
          cnt_next   = '0;
        end
      end
      WAIT1: begin
        if (!sync2) begin
          state_next = ZERO;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = ONE;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ONE: begin
        if (!sync2) begin
          state_next = WAIT0;
          cnt_next   = '0;
        end
      end
      WAIT0: begin
        if (sync2) begin
          state_next = ONE;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = ZERO;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ZERO;
        cnt_next   = '0;
      end
    endcase
  end

  assign db_level  = (state_reg == ONE) || (state_reg == WAIT0);
  assign rise_tick = rise_reg;
  assign fall_tick = fall_reg;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed, table-driven bench for debounce_edge with STABLE_CYCLES=4.
module tb_debounce_edge;

  logic clk = 1'b0;
  logic reset;
  logic raw_in;
  logic db_level;
  logic rise_tick;
  logic fall_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       raw;
    logic [2:0] exp; // {db_level, rise_tick, fall_tick}
  } vec_t;

  vec_t vecs[$];

  debounce_edge #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .db_level  (db_level),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always #10 clk = ~clk;

  task automatic add(input logic raw, input logic [2:0] exp, input int n);
    vec_t v;
    v.raw = raw;
    v.exp = exp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = {db_level, rise_tick, fall_tick};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: level/rise/fall got %b required %b", name, got, exp);
    end else begin
      $display("ok   %s: level/rise/fall %b", name, got);
    end
  endtask

  // Advance one edge and compare just after it.
  task automatic step_check(input string name, input logic [2:0] exp);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    // idle
    add(1'b0, 3'b000, 4);
    // clean rise: tick after the 6th edge past the first sampled 1
    add(1'b1, 3'b000, 6);
    add(1'b1, 3'b110, 1);
    add(1'b1, 3'b100, 3);
    // 2-cycle 0-glitch while ONE
    add(1'b0, 3'b100, 2);
    add(1'b1, 3'b100, 6);
    // clean fall
    add(1'b0, 3'b100, 6);
    add(1'b0, 3'b001, 1);
    add(1'b0, 3'b000, 3);
    // three 1-cycle glitches, then steady 1
    for (int i = 0; i < 3; i++) begin
      add(1'b1, 3'b000, 1);
      add(1'b0, 3'b000, 1);
    end
    add(1'b1, 3'b000, 6);
    add(1'b1, 3'b110, 1);
    add(1'b1, 3'b100, 2);

    // reset state
    reset  = 1'b1;
    raw_in = 1'b0;
    #5;
    check("reset_state", 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      raw_in = vecs[i].raw;
      step_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // asynchronous reset from ONE: outputs drop with no clock edge
    #5;
    reset = 1'b1;
    #1;
    check("async_reset_from_one", 3'b000);
    raw_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // sub-period pulses between edges never reach the FSM
    @(posedge clk); #5; raw_in = 1'b1; #2; raw_in = 1'b0;
    @(posedge clk); #5; raw_in = 1'b1; #3; raw_in = 1'b0;
    @(posedge clk); #5; raw_in = 1'b1; #4; raw_in = 1'b0;
    for (int i = 0; i < 8; i++) step_check($sformatf("short_pulse%0d", i), 3'b000);

    // reset while WAIT1 with cnt=2, then full debounce after release
    raw_in = 1'b1;
    for (int i = 0; i < 5; i++) step_check($sformatf("wait1_pre%0d", i), 3'b000);
    #5;
    reset = 1'b1;
    #1;
    check("reset_in_wait1", 3'b000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++)
      step_check($sformatf("post_reset%0d", i), (i == 6) ? 3'b110 : 3'b000);
    step_check("post_reset_hold", 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
